// File: rtl/spi_mem_if.sv
// SPI link between one master chip select and a memory-backed slave,
// plus the slave's frame status outputs.
interface spi_mem_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic busy;
  logic wr_done;
  logic rd_done;
  logic err;

  modport master (
    output sclk, cs_n, mosi,
    input  miso, miso_oe, busy, wr_done, rd_done, err
  );

  modport slave (
    input  sclk, cs_n, mosi,
    output miso, miso_oe, busy, wr_done, rd_done, err
  );
endinterface

// File: rtl/spi_mem_slave.sv
// SPI mode-0 responder backed by a local word memory: decodes CMD/ADDR/DATA
// frames, writes the addressed word or shifts it back on miso.
module spi_mem_slave #(
  parameter int DWIDTH     = 32,
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_HEIGHT = 1024,
  parameter int AWIDTH     = 15,
  parameter int CMD_WIDTH  = 8
) (
  input  logic      clk,
  input  logic      rst,
  spi_mem_if.slave  spi
);

  localparam int SW_AD = (DWIDTH > AWIDTH) ? DWIDTH : AWIDTH;
  localparam int SW    = (SW_AD > CMD_WIDTH) ? SW_AD : CMD_WIDTH;
  localparam int CW    = $clog2(SW + 1);
  localparam int IW    = $clog2(MEM_HEIGHT);

  localparam logic [CMD_WIDTH-1:0] CMD_WRITE = CMD_WIDTH'(8'h02);
  localparam logic [CMD_WIDTH-1:0] CMD_READ  = CMD_WIDTH'(8'h03);

  // Synchroniser reset values, ordered {mosi, cs_n, sclk}
  localparam logic [2:0] SYNC_RST = 3'b010;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_WR_MEM,
    ST_RD_MEM,
    ST_RD_LOAD,
    ST_RDATA,
    ST_DONE,
    ST_IGNORE
  } state_e;

  logic [2:0] sync_in;
  logic [2:0] sync_s;
  logic       sclk_s, cs_n_s, mosi_s;
  logic       sclk_q;
  logic       sclk_rise, sclk_fall;
  logic [1:0] settle_q;
  logic       armed_q;

  state_e         state_q, state_d;
  logic [SW-1:0]  shift_q, shift_d;
  logic [SW-1:0]  shift_in;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic           is_read_q, is_read_d;
  logic [IW-1:0]  widx_q, widx_d;
  logic           miso_q, miso_d;
  logic           err_q, err_d;
  logic           rd_done_q, rd_done_d;
  logic           mem_we, mem_re;

  logic [MEM_WIDTH-1:0] mem_q [MEM_HEIGHT];
  logic [MEM_WIDTH-1:0] rd_data_q;

  assign sync_in = {spi.mosi, spi.cs_n, spi.sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_q;
      logic stable_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          meta_q   <= SYNC_RST[gi];
          stable_q <= SYNC_RST[gi];
        end else begin
          meta_q   <= sync_in[gi];
          stable_q <= meta_q;
        end
      end
      assign sync_s[gi] = stable_q;
    end
  endgenerate

  assign sclk_s    = sync_s[0];
  assign cs_n_s    = sync_s[1];
  assign mosi_s    = sync_s[2];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign shift_in  = {shift_q[SW-2:0], mosi_s};

  // After reset, a frame is accepted only once cs_n has genuinely been seen
  // high, so the tail of an interrupted frame is never decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q    <= 1'b0;
      settle_q  <= 2'b00;
      armed_q   <= 1'b0;
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      is_read_q <= 1'b0;
      widx_q    <= '0;
      miso_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      sclk_q    <= sclk_s;
      settle_q  <= {settle_q[0], 1'b1};
      armed_q   <= armed_q | (settle_q[1] & cs_n_s);
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      is_read_q <= is_read_d;
      widx_q    <= widx_d;
      miso_q    <= miso_d;
      err_q     <= err_d;
      rd_done_q <= rd_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    is_read_d = is_read_q;
    widx_d    = widx_q;
    miso_d    = miso_q;
    err_d     = 1'b0;
    rd_done_d = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        shift_d   = '0;
        miso_d    = 1'b0;
        if (!cs_n_s && armed_q) state_d = ST_CMD;
      end

      ST_CMD: begin
        if (cs_n_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(CMD_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (shift_in[CMD_WIDTH-1:0] == CMD_WRITE) begin
              is_read_d = 1'b0;
              state_d   = ST_ADDR;
            end else if (shift_in[CMD_WIDTH-1:0] == CMD_READ) begin
              is_read_d = 1'b1;
              state_d   = ST_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IGNORE;
            end
          end
        end
      end

      ST_ADDR: begin
        if (cs_n_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(AWIDTH - 1)) begin
            bit_cnt_d = '0;
            // Byte address -> word index; bits above the memory depth alias.
            widx_d    = shift_in[IW+1:2];
            state_d   = is_read_q ? ST_RD_MEM : ST_WDATA;
          end
        end
      end

      ST_WDATA: begin
        // The final data edge wins over a simultaneous cs_n rise.
        if (sclk_rise && bit_cnt_q == CW'(DWIDTH - 1)) begin
          shift_d   = shift_in;
          bit_cnt_d = '0;
          state_d   = ST_WR_MEM;
        end else if (cs_n_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          shift_d   = shift_in;
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end

      ST_WR_MEM: begin
        mem_we  = ~rst;
        state_d = ST_DONE;
      end

      ST_RD_MEM: begin
        mem_re  = 1'b1;
        state_d = ST_RD_LOAD;
      end

      ST_RD_LOAD: begin
        shift_d   = SW'(rd_data_q);
        bit_cnt_d = '0;
        miso_d    = 1'b0;
        state_d   = ST_RDATA;
      end

      ST_RDATA: begin
        if (cs_n_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          miso_d  = 1'b0;
        end else if (sclk_fall) begin
          if (bit_cnt_q == CW'(DWIDTH)) begin
            rd_done_d = 1'b1;
            miso_d    = 1'b0;
            state_d   = ST_DONE;
          end else begin
            miso_d    = shift_q[DWIDTH-1];
            shift_d   = {shift_q[SW-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end

      ST_DONE, ST_IGNORE: begin
        if (cs_n_s) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx_q] <= shift_q[MEM_WIDTH-1:0];
    if (mem_re) rd_data_q <= mem_q[widx_q];
  end

  assign spi.miso_oe = (state_q == ST_RDATA);
  assign spi.miso    = miso_q & (state_q == ST_RDATA);
  assign spi.busy    = (state_q != ST_IDLE);
  assign spi.wr_done = (state_q == ST_WR_MEM) & ~rst;
  assign spi.rd_done = rd_done_q;
  assign spi.err     = err_q;

endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: table of SPI frames with a memory model and a
// read-data scoreboard, plus hand sequences for back-to-back and reset cases.
module tb_spi_mem_slave;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_mem_if bus ();

  spi_mem_slave dut (
    .clk (clk),
    .rst (rst),
    .spi (bus)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [14:0] addr;
    logic [31:0] data;
    int          ncyc;
    int          hp;
    int          exp_wr;
    int          exp_rd;
    int          exp_err;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  logic [31:0] model [logic [12:0]];
  logic [31:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, bad_miso = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_done) wr_cnt  <= wr_cnt + 1;
      if (bus.rd_done) rd_cnt  <= rd_cnt + 1;
      if (bus.err)     err_cnt <= err_cnt + 1;
      if (bus.miso && !bus.miso_oe) bad_miso <= bad_miso + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode-0 master: mosi changes after falling sclk, miso sampled just before rising sclk.
  task automatic spi_frame(input logic [7:0] cmd, input logic [14:0] addr,
                           input logic [31:0] wdata, input int ncyc, input int hp,
                           input bit keep_cs, output logic [31:0] rdata);
    logic [54:0] frame;
    frame = {cmd, addr, wdata};
    rdata = '0;
    bus.cs_n = 1'b0;
    bus.mosi = frame[54];
    wait_clks(hp);
    for (int i = 0; i < ncyc; i++) begin
      if (i >= 23 && i < 55) rdata = {rdata[30:0], bus.miso};
      bus.sclk = 1'b1;
      wait_clks(hp);
      bus.sclk = 1'b0;
      bus.mosi = (i + 1 < 55) ? frame[54 - (i + 1)] : 1'b0;
      wait_clks(hp);
    end
    if (!keep_cs) begin
      bus.cs_n = 1'b1;
      bus.mosi = 1'b0;
      wait_clks(2 * hp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int w0, r0, e0;
    logic [31:0] rd, req;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    if (v.cmd == 8'h03 && v.exp_rd == 1) exp_q.push_back(model[v.addr[14:2]]);
    spi_frame(v.cmd, v.addr, v.data, v.ncyc, v.hp, 1'b0, rd);
    wait_clks(4);
    check({tag, "_wr_done"}, 32'(wr_cnt - w0), 32'(v.exp_wr));
    check({tag, "_rd_done"}, 32'(rd_cnt - r0), 32'(v.exp_rd));
    check({tag, "_err"},     32'(err_cnt - e0), 32'(v.exp_err));
    check({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    if (v.cmd == 8'h03 && v.exp_rd == 1) begin
      req = exp_q.pop_front();
      check({tag, "_rdata"}, rd, req);
    end
    if (v.cmd == 8'h02 && v.exp_wr == 1) model[v.addr[14:2]] = v.data;
    $display("txn %s cmd=%h addr=%h wdata=%h rdata=%h", tag, v.cmd, v.addr, v.data, rd);
  endtask

  initial begin
    logic [31:0] rd;
    int w0, r0, e0;

    vecs[0]  = '{8'h02, 15'h0010, 32'hDEADBEEF, 55, 6, 1, 0, 0};
    vecs[1]  = '{8'h03, 15'h0010, 32'h0,        55, 6, 0, 1, 0};
    vecs[2]  = '{8'h02, 15'h7FFE, 32'h12345678, 55, 6, 1, 0, 0};
    vecs[3]  = '{8'h03, 15'h7FFC, 32'h0,        55, 6, 0, 1, 0};
    vecs[4]  = '{8'h02, 15'h0020, 32'hA5A50F0F, 55, 6, 1, 0, 0};
    vecs[5]  = '{8'h02, 15'h0020, 32'hFFFF0000, 43, 6, 0, 0, 1};
    vecs[6]  = '{8'h03, 15'h0020, 32'h0,        55, 6, 0, 1, 0};
    vecs[7]  = '{8'hFF, 15'h0000, 32'h0,        55, 6, 0, 0, 1};
    vecs[8]  = '{8'h02, 15'h0004, 32'hCAFEF00D, 55, 4, 1, 0, 0};
    vecs[9]  = '{8'h03, 15'h0004, 32'h0,        55, 4, 0, 1, 0};
    vecs[10] = '{8'h02, 15'h0013, 32'h0BADF00D, 55, 5, 1, 0, 0};
    vecs[11] = '{8'h03, 15'h0010, 32'h0,        55, 5, 0, 1, 0};

    rst      = 1'b1;
    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    wait_clks(3);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_miso",    32'(bus.miso),    32'd0);
    check("rst_miso_oe", 32'(bus.miso_oe), 32'd0);
    check("rst_wr_done", 32'(bus.wr_done), 32'd0);
    check("rst_rd_done", 32'(bus.rd_done), 32'd0);
    check("rst_err",     32'(bus.err),     32'd0);
    rst = 1'b0;
    wait_clks(6);

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a read data field
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    spi_frame(8'h03, 15'h0010, 32'h0, 33, 6, 1'b1, rd);
    check("mid_rd_miso_oe", 32'(bus.miso_oe), 32'd1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check("post_rst_miso", 32'(bus.miso), 32'd0);
    check("post_rst_busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.sclk = 1'b1;
      wait_clks(6);
      bus.sclk = 1'b0;
      wait_clks(6);
    end
    check("tail_ignored_busy", 32'(bus.busy), 32'd0);
    bus.cs_n = 1'b1;
    wait_clks(12);
    check("rst_seq_wr", 32'(wr_cnt - w0), 32'd0);
    check("rst_seq_rd", 32'(rd_cnt - r0), 32'd0);
    check("rst_seq_err", 32'(err_cnt - e0), 32'd0);
    $display("txn rst_mid_read busy=%0d miso=%0d", bus.busy, bus.miso);

    run_vec('{8'h03, 15'h0004, 32'h0, 55, 6, 0, 1, 0}, "after_rst_a");
    run_vec('{8'h03, 15'h7FFC, 32'h0, 55, 6, 0, 1, 0}, "after_rst_b");

    check("miso_outside_oe", 32'(bad_miso), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
